// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: two-requester round-robin write FIFO that replays (reg,val) pairs as timed OPL address/data writes.
// Optional macro JTOPL_WRSEQ_SKIPADDR_EN: skip the address write when the register matches the last one written.
`default_nettype none

module jtopl_wrseq #(
  parameter int FW      = 2,
  parameter int AW_WAIT = 12,
  parameter int DW_WAIT = 84
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cen,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [7:0]    a_reg,
  input  logic [7:0]    a_val,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [7:0]    b_reg,
  input  logic [7:0]    b_val,
  output logic [FW:0]   level,
  output logic          busy,
  output logic          opl_addr,
  output logic [7:0]    opl_din,
  output logic          opl_cs_n,
  output logic          opl_wr_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ASTB  = 3'd1;
  localparam logic [2:0] S_AWAIT = 3'd2;
  localparam logic [2:0] S_DSTB  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;

  localparam int          DEPTH   = 1 << FW;
  localparam logic [FW:0] C_DEPTH = DEPTH[FW:0];
  localparam logic [7:0]  C_AW    = AW_WAIT[7:0];
  localparam logic [7:0]  C_DW    = DW_WAIT[7:0];

  logic [15:0]   r_mem [0:DEPTH-1];
  logic [FW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FW:0]   r_level;
  logic          r_full;
  logic          r_last_b;
  logic [2:0]    r_state;
  logic [7:0]    r_cnt;
  logic [7:0]    r_val;
  logic          r_addr, r_cs_n, r_wr_n;
  logic [7:0]    r_din;

  logic          w_grant_a, w_grant_b, w_push, w_pop, w_skip;
  logic [15:0]   w_push_data, w_head;
  logic [FW:0]   w_level_nxt;

  assign w_grant_a   = a_valid & ~r_full & (~b_valid | r_last_b);
  assign w_grant_b   = b_valid & ~r_full & ~w_grant_a;
  assign w_push      = w_grant_a | w_grant_b;
  assign w_push_data = w_grant_a ? {a_reg, a_val} : {b_reg, b_val};
  assign w_head      = r_mem[r_rd_ptr];

  // A pop may also happen on the last DWAIT pulse so back-to-back writes lose no cen pulse.
  assign w_pop = cen & (r_level != '0) &
                 ((r_state == S_IDLE) | ((r_state == S_DWAIT) & (r_cnt == 8'd1)));

  assign w_level_nxt = r_level + {{FW{1'b0}}, w_push} - {{FW{1'b0}}, w_pop};

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign level    = r_level;
  assign busy     = (r_level != '0) | (r_state != S_IDLE);
  assign opl_addr = r_addr;
  assign opl_din  = r_din;
  assign opl_cs_n = r_cs_n;
  assign opl_wr_n = r_wr_n;

`ifdef JTOPL_WRSEQ_SKIPADDR_EN
  logic [7:0] r_last_reg;
  logic       r_last_vld;

  assign w_skip = r_last_vld & (w_head[15:8] == r_last_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_reg <= 8'd0;
      r_last_vld <= 1'b0;
    end else if (w_pop & ~w_skip) begin
      r_last_reg <= w_head[15:8];
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // Full is registered, so a same-cycle pop never frees room for a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_last_b <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FW'(1);
        r_last_b <= w_grant_b;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == C_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_val   <= 8'd0;
      r_addr  <= 1'b0;
      r_din   <= 8'd0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
    end else if (cen) begin
      case (r_state)
        S_IDLE, S_DWAIT: begin
          if (w_pop) begin
            r_val <= w_head[7:0];
            if (w_skip) begin
              r_state <= S_AWAIT;
              r_cnt   <= 8'd1;
            end else begin
              r_addr  <= 1'b0;
              r_din   <= w_head[15:8];
              r_cs_n  <= 1'b0;
              r_wr_n  <= 1'b0;
              r_state <= S_ASTB;
            end
          end else if (r_state == S_DWAIT) begin
            if (r_cnt == 8'd1) r_state <= S_IDLE;
            else               r_cnt   <= r_cnt - 8'd1;
          end
        end
        S_ASTB: begin
          r_cs_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_cnt   <= C_AW;
          r_state <= S_AWAIT;
        end
        S_AWAIT: begin
          if (r_cnt == 8'd1) begin
            r_addr  <= 1'b1;
            r_din   <= r_val;
            r_cs_n  <= 1'b0;
            r_wr_n  <= 1'b0;
            r_state <= S_DSTB;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DSTB: begin
          r_cs_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_cnt   <= C_DW;
          r_state <= S_DWAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq: directed, scoreboard-based bench for jtopl_wrseq (default parameters).
`default_nettype none
`timescale 1ns/1ps

module tb_jtopl_wrseq;

  logic       rst_n, clk, cen;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_reg, a_val, b_reg, b_val;
  logic [2:0] level;
  logic       busy, opl_addr, opl_cs_n, opl_wr_n;
  logic [7:0] opl_din;

  jtopl_wrseq dut (
    .rst_n(rst_n), .clk(clk), .cen(cen),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_val(a_val),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_val(b_val),
    .level(level), .busy(busy),
    .opl_addr(opl_addr), .opl_din(opl_din), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cen_mode = 1;  // 0 low, 1 high, 2 one-in-four, 3 driven by the main sequence
  int div = 0;

  logic [15:0] q[$];
  int astb_log[$];
  int n_astb = 0, n_dstb = 0, dstb_cyc = 0;
  int cur_len = 0, len_a = 0, len_d = 0;
  logic prev_w = 1'b0, cur_data = 1'b0;
  logic [7:0] last_areg = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cen_mode == 0) cen = 1'b0;
    else if (cen_mode == 1) cen = 1'b1;
    else if (cen_mode == 2) begin
      cen = (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: observed event missing, expected event present", tag);
  endtask

  // Bus monitor: detects strobe starts, checks them against the scoreboard, measures strobe length.
  initial forever begin
    logic w;
    @(negedge clk);
    w = rst_n & ~opl_cs_n & ~opl_wr_n;
    if (w && !prev_w) begin
      cur_len  = 1;
      cur_data = opl_addr;
      if (!opl_addr) begin
        n_astb++;
        astb_log.push_back(cyc);
        last_areg = opl_din;
        if (q.size() == 0) fail_now("addr_sb_underflow");
        else chk("addr_reg", 32'(opl_din), 32'(q[0][15:8]));
      end else begin
        n_dstb++;
        dstb_cyc = cyc;
        if (q.size() == 0) fail_now("data_sb_underflow");
        else begin
          chk("data_reg", 32'(last_areg), 32'(q[0][15:8]));
          chk("data_val", 32'(opl_din), 32'(q[0][7:0]));
          void'(q.pop_front());
        end
      end
    end else if (w) begin
      cur_len++;
    end else if (prev_w) begin
      if (cur_data) len_d = cur_len;
      else          len_a = cur_len;
    end
    prev_w = w;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    q.delete();
    astb_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] r, input logic [7:0] v);
    int t;
    t = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_reg = r;
    a_val = v;
    #1;
    while (!a_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!a_ready) fail_now("a_grant_timeout");
    else q.push_back({r, v});
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int c);
    int t;
    t = 0;
    c = -1;
    while (t < max) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        c = cyc;
        break;
      end
      t++;
    end
    if (c < 0) fail_now("idle_timeout");
  endtask

  initial begin
    int c, ia, ib, na, nd;
    logic exp_a, seen_full, got_a;

    rst_n = 1'b0; cen = 1'b1;
    a_valid = 1'b0; a_reg = 8'd0; a_val = 8'd0;
    b_valid = 1'b0; b_reg = 8'd0; b_val = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({opl_cs_n, opl_wr_n}), 32'b11);
    chk("rst_addr_din", 32'({opl_addr, opl_din}), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, cen always high.
    send_a(8'h20, 8'h01);
    wait_idle(400, c);
    chk("t1_astb_count", 32'(n_astb), 32'd1);
    chk("t1_dstb_count", 32'(n_dstb), 32'd1);
    chk("t1_addr_to_data", 32'(dstb_cyc - astb_log[0]), 32'd13);
    chk("t1_data_to_idle", 32'(c - dstb_cyc), 32'd85);
    chk("t1_len_a", 32'(len_a), 32'd1);
    chk("t1_len_d", 32'(len_d), 32'd1);

    // Both requesters continuously valid: grants must alternate starting with A.
    do_reset();
    ia = 0; ib = 0; exp_a = 1'b1; seen_full = 1'b0;
    a_valid = 1'b1; a_reg = 8'h10; a_val = 8'hA0;
    b_valid = 1'b1; b_reg = 8'h80; b_val = 8'h50;
    for (int t = 0; t < 2000 && (ia < 4 || ib < 4); t++) begin
      #1;
      if (level == 3'd4 && !seen_full) begin
        seen_full = 1'b1;
        chk("t2_ready_when_full", 32'({a_ready, b_ready}), 32'd0);
      end
      if (a_ready || b_ready) begin
        chk("t2_grant_side", 32'({a_ready, b_ready}), exp_a ? 32'b10 : 32'b01);
        got_a = a_ready;
        if (a_ready) begin q.push_back({a_reg, a_val}); ia++; end
        else         begin q.push_back({b_reg, b_val}); ib++; end
        exp_a = (ia < 4 && ib < 4) ? ~got_a : (ia < 4);
      end
      @(negedge clk);
      a_valid = (ia < 4); a_reg = 8'h10 + 8'(ia); a_val = 8'hA0 + 8'(ia);
      b_valid = (ib < 4); b_reg = 8'h80 + 8'(ib); b_val = 8'h50 + 8'(ib);
    end
    chk("t2_grants", 32'(ia + ib), 32'd8);
    chk("t2_seen_full", 32'(seen_full), 32'd1);
    wait_idle(1500, c);
    chk("t2_astb_count", 32'(astb_log.size()), 32'd8);
    for (int i = 1; i < astb_log.size(); i++)
      chk("t2_astb_spacing", 32'(astb_log[i] - astb_log[i-1]), 32'd98);

    // cen one pulse in four.
    do_reset();
    cen_mode = 2;
    send_a(8'h33, 8'h44);
    wait_idle(1000, c);
    chk("t3_addr_to_data", 32'(dstb_cyc - astb_log[0]), 32'd52);
    chk("t3_len_a", 32'(len_a), 32'd4);
    chk("t3_len_d", 32'(len_d), 32'd4);
    cen_mode = 1;

    // Reset in AWAIT with three entries queued.
    do_reset();
    send_a(8'h01, 8'h11);
    send_a(8'h02, 8'h22);
    send_a(8'h03, 8'h33);
    send_a(8'h04, 8'h44);
    #1;
    chk("t4_level_before", 32'(level), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_strobes", 32'({opl_cs_n, opl_wr_n}), 32'b11);
    chk("t4_level", 32'(level), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    q.delete();
    na = n_astb; nd = n_dstb;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    chk("t4_no_astb", 32'(n_astb), 32'(na));
    chk("t4_no_dstb", 32'(n_dstb), 32'(nd));

    // Push attempted while full in the same clk as a pop.
    do_reset();
    cen_mode = 3;
    cen = 1'b0;
    for (int i = 0; i < 4; i++) send_a(8'h60 + 8'(i), 8'h70 + 8'(i));
    #1;
    chk("t5_level_full", 32'(level), 32'd4);
    @(negedge clk);
    a_valid = 1'b1; a_reg = 8'h6F; a_val = 8'h7F;
    cen = 1'b1;
    #1;
    chk("t5_ready_full_pop", 32'(a_ready), 32'd0);
    @(negedge clk);
    cen = 1'b0;
    #1;
    chk("t5_level_after_pop", 32'(level), 32'd3);
    chk("t5_ready_next", 32'(a_ready), 32'd1);
    q.push_back({8'h6F, 8'h7F});
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("t5_level_end", 32'(level), 32'd4);
    cen_mode = 1;
    wait_idle(1000, c);
    chk("t5_sb_drained", 32'(q.size()), 32'd0);

`ifdef JTOPL_WRSEQ_SKIPADDR_EN
    // Repeated register: second write issues only a data strobe.
    do_reset();
    na = n_astb; nd = n_dstb;
    send_a(8'hA0, 8'h01);
    send_a(8'hA0, 8'h02);
    c = dstb_cyc;
    wait_idle(400, c);
    chk("t6_astb_count", 32'(n_astb - na), 32'd1);
    chk("t6_dstb_count", 32'(n_dstb - nd), 32'd2);
    chk("t6_second_data_gap", 32'(dstb_cyc - astb_log[0]), 32'd99);
`endif

    chk("final_sb_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtopl_wrseq.md
Name: jtopl_wrseq

Overview:
- Write sequencer/arbiter placed in front of the jtopl CPU port.
- Accepts (register, value) write requests from two independent requesters and arbitrates them round-robin into a shared FIFO.
- Replays each entry as an OPL address write followed by a data write on addr/din/cs_n/wr_n.
- Enforces the chip's post-address and post-data wait intervals, counted in cen pulses, so requesters never need to time the OPL bus themselves.

Parameters:
- FW, 2: FIFO address width; depth = 2**FW entries.
- AW_WAIT, 12: cen pulses to wait after the address write strobe. Legal range 1..255.
- DW_WAIT, 84: cen pulses to wait after the data write strobe. Legal range 1..255.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  single clock
- cen  in  1  clock enable shared with jtopl; all OPL timing is counted in cen pulses
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  requester A write accepted this clk (combinational)
- a_reg  in  8  requester A OPL register number
- a_val  in  8  requester A data value
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  requester B write accepted this clk (combinational)
- b_reg  in  8  requester B OPL register number
- b_val  in  8  requester B data value
- level  out  FW+1  FIFO occupancy
- busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE
- opl_addr  out  1  to jtopl addr
- opl_din  out  8  to jtopl din
- opl_cs_n  out  1  to jtopl cs_n
- opl_wr_n  out  1  to jtopl wr_n

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty, level=0, FSM IDLE, counter=0.
  - opl_cs_n=1, opl_wr_n=1, opl_addr=0, opl_din=0, busy=0.
  - Round-robin pointer set so A wins the first tie.
  - Asserting reset mid-sequence releases the strobes immediately and discards all queued entries.
- Arbitration (every clk, independent of cen):
  - full = registered (level == 2**FW).
  - Ready equations:
    - grant_a = a_valid & ~full & (~b_valid | last_was_b)
    - grant_b = b_valid & ~full & ~grant_a
    - a_ready = grant_a; b_ready = grant_b
  - At most one push per clk; the pointer updates only when a grant occurs.
  - Push and pop in the same clk are allowed. A pop does not free a slot for a push in the same clk because full is registered.
- FIFO:
  - Entry = {reg[7:0], val[7:0]}.
  - Wrap-around read/write pointers; level tracks occupancy exactly.
- FSM (advances only on clk with cen=1):
  - IDLE: if level>0, pop one entry, drive opl_addr=0, opl_din=reg, opl_cs_n=opl_wr_n=0 -> ASTB.
  - ASTB: release strobes (cs_n=wr_n=1), counter=AW_WAIT -> AWAIT.
  - AWAIT: decrement counter on each cen; when counter reaches 1, drive opl_addr=1, opl_din=val, strobes low -> DSTB.
  - DSTB: release strobes, counter=DW_WAIT -> DWAIT.
  - DWAIT: decrement on each cen; when counter reaches 1 -> IDLE.
- Timing:
  - Each strobe is low for exactly one cen period.
  - opl_addr and opl_din are stable for the whole strobe period and held after it.
  - Address strobe at cen pulse k; data strobe at pulse k+AW_WAIT+1.
  - Earliest next address strobe at pulse k+AW_WAIT+DW_WAIT+2, i.e. 98 pulses with default parameters.
- cen low: FSM, counter and strobes hold; the FIFO and arbiter still accept requests.
- Stale entry: the popped entry is latched at the pop, so a later FIFO push cannot alter an in-flight write.

Optional Feature:
- Macro: JTOPL_WRSEQ_SKIPADDR_EN.
- Defined:
  - A register last_reg plus a valid bit, cleared by reset, remembers the last address written.
  - When a popped reg equals last_reg and the valid bit is set, the FSM goes IDLE -> AWAIT directly with counter=1, skipping the address strobe and its wait.
  - The data strobe then occurs on the next cen pulse after the pop.
- Undefined: every entry always performs the full address+data sequence; last_reg logic is absent.

Test Plan (defaults FW=2, AW_WAIT=12, DW_WAIT=84, cen=1 unless noted):
- Single write A reg=0x20 val=0x01 -> address strobe with opl_addr=0, opl_din=0x20; 13 clks later data strobe with opl_addr=1, opl_din=0x01; busy falls 85 clks after the data strobe.
- A and B both valid continuously, 4 writes each -> grants alternate A,B,A,B…; the FIFO fills to level=4 and ready drops while full; OPL writes appear in grant order with address strobes spaced exactly 98 clks apart.
- cen pulsing 1-in-4 clks, single write -> every strobe lasts 4 clks; data strobe 52 clks after the address strobe.
- rst_n pulsed low during AWAIT with 3 entries queued -> strobes are 1 immediately; level=0, busy=0; no further OPL writes.
- Push while full and a pop occurs in the same clk -> push not accepted that clk; accepted on the next clk; level ends at 4.
- JTOPL_WRSEQ_SKIPADDR_EN defined, two writes to reg 0xA0 -> the second write issues only a data strobe, one cen pulse after its pop.
